// File: rtl/adder_operand_issuer.sv
// Operand-pair FIFO feeding a two-operand AXI-Stream adder: each buffered
// pair {A,B,ID} is sent as a two-beat packet (A with TLAST=0, then B with TLAST=1).
module adder_operand_issuer #(
  parameter int TDATAW = 32,
  parameter int TDESTW = 4,
  parameter int TIDW   = 2,
  parameter int DEPTH  = 4,
  parameter int DEST   = 0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       PAIR_VALID,
  output logic                       PAIR_READY,
  input  logic [TDATAW-1:0]          PAIR_A,
  input  logic [TDATAW-1:0]          PAIR_B,
  input  logic [TIDW-1:0]            PAIR_ID,
  output logic                       AXIS_M_TVALID,
  input  logic                       AXIS_M_TREADY,
  output logic [TDATAW-1:0]          AXIS_M_TDATA,
  output logic                       AXIS_M_TLAST,
  output logic [TIDW-1:0]            AXIS_M_TID,
  output logic [TDESTW-1:0]          AXIS_M_TDEST,
  output logic [$clog2(DEPTH):0]     PAIR_COUNT,
  output logic [15:0]                ISSUED_COUNT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [0:0] PH_A = 1'b0;
  localparam logic [0:0] PH_B = 1'b1;

  logic [TDATAW-1:0] mem_a  [DEPTH];
  logic [TDATAW-1:0] mem_b  [DEPTH];
  logic [TIDW-1:0]   mem_id [DEPTH];

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic [15:0]   issued;
  logic [0:0]    phase;

  logic pair_ready;
  logic tvalid;
  logic push;
  logic hs;
  logic pop;

  // Readiness is taken from the registered count only, so a full FIFO
  // refuses a pair even in a cycle where the head is being popped.
  assign pair_ready = (count != FULL_COUNT);
  assign tvalid     = (count != '0);
  assign push       = PAIR_VALID && pair_ready;
  assign hs         = tvalid && AXIS_M_TREADY;
  assign pop        = hs && (phase == PH_B);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      issued <= '0;
      phase  <= PH_A;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop) begin
        rptr   <= rptr + PW'(1);
        issued <= issued + 16'd1;
      end
      if (hs) phase <= (phase == PH_A) ? PH_B : PH_A;
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_a[wptr]  <= PAIR_A;
      mem_b[wptr]  <= PAIR_B;
      mem_id[wptr] <= PAIR_ID;
    end
  end

  always_comb begin
    AXIS_M_TDATA = '0;
    AXIS_M_TLAST = 1'b0;
    AXIS_M_TID   = '0;
    AXIS_M_TDEST = '0;
    if (tvalid) begin
      AXIS_M_TDATA = (phase == PH_B) ? mem_b[rptr] : mem_a[rptr];
      AXIS_M_TLAST = (phase == PH_B);
      AXIS_M_TID   = mem_id[rptr];
      AXIS_M_TDEST = TDESTW'(DEST);
    end
  end

  assign PAIR_READY    = pair_ready;
  assign AXIS_M_TVALID = tvalid;
  assign PAIR_COUNT    = count;
  assign ISSUED_COUNT  = issued;

endmodule
